// File: rtl/dvs_event_fifo_reader.sv
// Multi-channel DVS event reader: round-robin over NUM_CH event FIFOs with req/grant
// handshake, bursted read strobes and a small FWFT output buffer tagged with the source channel.

package dvs_ravens_pkg;
  localparam int EVENT_BITS = 32;
endpackage

module dvs_event_fifo_reader #(
  parameter int NUM_CH     = 2,
  parameter int EVENT_BITS = dvs_ravens_pkg::EVENT_BITS,
  parameter int RD_LATENCY = 1,
  parameter int BURST_LEN  = 4,
  parameter int OUT_DEPTH  = 4,
  parameter int CH_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            fifo_empty,
  input  logic [NUM_CH-1:0]            fifo_grant,
  input  logic [NUM_CH*EVENT_BITS-1:0] fifo_event,
  output logic [NUM_CH-1:0]            fifo_req,
  output logic [NUM_CH-1:0]            fifo_rd_en,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [EVENT_BITS-1:0]        ev_data,
  output logic [CH_BITS-1:0]           ev_ch
);

  localparam int PTR_BITS   = $clog2(OUT_DEPTH);
  localparam int LAT_BITS   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int BURST_BITS = $clog2(BURST_LEN + 1);

  localparam logic [PTR_BITS:0]     DEPTH_VAL = (PTR_BITS + 1)'(OUT_DEPTH);
  localparam logic [LAT_BITS-1:0]   LAT_LAST  = LAT_BITS'(RD_LATENCY - 1);
  localparam logic [BURST_BITS-1:0] BURST_MAX = BURST_BITS'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ_CTRL,
    S_READ,
    S_RELEASE
  } state_t;

  state_t                  r_state;
  logic [CH_BITS-1:0]      r_sel;
  logic [CH_BITS-1:0]      r_rr_ptr;
  logic [BURST_BITS-1:0]   r_burst_cnt;
  logic [LAT_BITS-1:0]     r_lat;
  logic [NUM_CH-1:0]       r_req;
  logic [NUM_CH-1:0]       r_rd_en;

  logic [PTR_BITS-1:0]     r_wr_ptr;
  logic [PTR_BITS-1:0]     r_rd_ptr;
  logic [PTR_BITS:0]       r_occ;
  logic [EVENT_BITS-1:0]   r_mem_data [OUT_DEPTH];
  logic [CH_BITS-1:0]      r_mem_ch   [OUT_DEPTH];

  logic                    w_found;
  logic [CH_BITS-1:0]      w_found_ch;
  logic [CH_BITS-1:0]      w_cand;
  logic [NUM_CH-1:0]       w_found_onehot;
  logic [NUM_CH-1:0]       w_sel_onehot;
  logic                    w_sel_empty;
  logic                    w_sel_grant;
  logic [EVENT_BITS-1:0]   w_sel_event;
  logic                    w_lat_last;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_has_room;
  logic [PTR_BITS:0]       w_occ_after_push;
  logic                    w_room_after_push;
  logic                    w_continue;

  function automatic logic [CH_BITS-1:0] wrap_add(input logic [CH_BITS-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_BITS'(s);
  endfunction

  // Descending scan so the channel closest to rr_ptr is the one left standing.
  always_comb begin
    w_found    = 1'b0;
    w_found_ch = '0;
    w_cand     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_cand = wrap_add(r_rr_ptr, i);
      if (!fifo_empty[w_cand]) begin
        w_found    = 1'b1;
        w_found_ch = w_cand;
      end
    end
  end

  assign w_found_onehot = NUM_CH'(1) << w_found_ch;
  assign w_sel_onehot   = NUM_CH'(1) << r_sel;
  assign w_sel_empty    = fifo_empty[r_sel];
  assign w_sel_grant    = fifo_grant[r_sel];
  assign w_sel_event    = fifo_event[r_sel*EVENT_BITS +: EVENT_BITS];

  assign w_lat_last        = (r_lat == LAT_LAST);
  assign w_push            = (r_state == S_READ) && w_lat_last;
  assign w_pop             = ev_valid && ev_ready;
  assign w_has_room        = (r_occ < DEPTH_VAL);
  assign w_occ_after_push  = r_occ + 1'b1 - {{PTR_BITS{1'b0}}, w_pop};
  assign w_room_after_push = (w_occ_after_push < DEPTH_VAL);
  assign w_continue        = (r_burst_cnt < BURST_MAX) && w_sel_grant && !w_sel_empty
                             && w_room_after_push;

  // Request and strobe are registered alongside the state, so grant never reaches them combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_lat       <= '0;
      r_req       <= '0;
      r_rd_en     <= '0;
    end else begin
      r_rd_en <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sel   <= w_found_ch;
            r_req   <= w_found_onehot;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_sel_empty) begin
            r_req   <= '0;
            r_state <= S_RELEASE;
          end else if (w_sel_grant && w_has_room) begin
            r_rd_en <= w_sel_onehot;
            r_state <= S_READ_CTRL;
          end
        end
        S_READ_CTRL: begin
          r_burst_cnt <= r_burst_cnt + 1'b1;
          r_lat       <= '0;
          r_state     <= S_READ;
        end
        S_READ: begin
          if (w_lat_last) begin
            r_lat <= '0;
            if (w_continue) begin
              r_rd_en <= w_sel_onehot;
              r_state <= S_READ_CTRL;
            end else begin
              r_req   <= '0;
              r_state <= S_RELEASE;
            end
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        S_RELEASE: begin
          r_rr_ptr    <= wrap_add(r_sel, 1);
          r_burst_cnt <= '0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_req   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage carries no reset; the head is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_sel_event;
      r_mem_ch[r_wr_ptr]   <= r_sel;
    end
  end

  assign fifo_req   = r_req;
  assign fifo_rd_en = r_rd_en;
  assign ev_valid   = (r_occ != '0);
  assign ev_data    = ev_valid ? r_mem_data[r_rd_ptr] : '0;
  assign ev_ch      = ev_valid ? r_mem_ch[r_rd_ptr] : '0;

endmodule

// File: tb/tb_dvs_event_fifo_reader.sv
// Directed bench for dvs_event_fifo_reader: instance 0 uses read latency 1, instance 1 latency 3;
// both are fed by a behavioural FIFO model that only drives valid data in the capture cycle.
`timescale 1ns/1ps

module tb_dvs_event_fifo_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  empty    [2];
  logic [1:0]  grant    [2];
  logic [1:0]  req      [2];
  logic [1:0]  rd_en    [2];
  logic [63:0] fev      [2];
  logic        ev_valid [2];
  logic        ev_ready [2];
  logic [31:0] ev_data  [2];
  logic        ev_ch    [2];

  int          avail     [2][2];
  int          rd_count  [2][2];
  int          pend_cnt  [2][2];
  logic [31:0] pend_word [2][2];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  int          rd_cyc_q   [2][$];
  int          rd_ch_q    [2][$];
  int          pop_cyc_q  [2][$];
  int          pop_ch_q   [2][$];
  logic [31:0] pop_data_q [2][$];

  always #5 clk = ~clk;

  dvs_event_fifo_reader #(
    .NUM_CH(2), .EVENT_BITS(32), .RD_LATENCY(1), .BURST_LEN(4), .OUT_DEPTH(4)
  ) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .fifo_empty(empty[0]), .fifo_grant(grant[0]), .fifo_event(fev[0]),
    .fifo_req(req[0]), .fifo_rd_en(rd_en[0]),
    .ev_valid(ev_valid[0]), .ev_ready(ev_ready[0]), .ev_data(ev_data[0]), .ev_ch(ev_ch[0])
  );

  dvs_event_fifo_reader #(
    .NUM_CH(2), .EVENT_BITS(32), .RD_LATENCY(3), .BURST_LEN(4), .OUT_DEPTH(4)
  ) u_dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .fifo_empty(empty[1]), .fifo_grant(grant[1]), .fifo_event(fev[1]),
    .fifo_req(req[1]), .fifo_rd_en(rd_en[1]),
    .ev_valid(ev_valid[1]), .ev_ready(ev_ready[1]), .ev_data(ev_data[1]), .ev_ch(ev_ch[1])
  );

  function automatic logic [31:0] word(input int i, input int k, input int j);
    return 32'hA5A5_0001 + 32'(i) * 32'h100 + 32'(k) * 32'h1000 + 32'(j);
  endfunction

  function automatic int qi(input int q[$], input int j);
    return (j < q.size()) ? q[j] : -1;
  endfunction

  function automatic logic [31:0] qd(input logic [31:0] q[$], input int j);
    return (j < q.size()) ? q[j] : 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  // FIFO model: word count advances on each strobe; data is valid only in the cycle L after it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (rd_en[i][k]) begin
          rd_count[i][k]  <= rd_count[i][k] + 1;
          pend_cnt[i][k]  <= (i == 0) ? 1 : 3;
          pend_word[i][k] <= word(i, k, rd_count[i][k]);
        end else if (pend_cnt[i][k] > 0) begin
          pend_cnt[i][k] <= pend_cnt[i][k] - 1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = '0;
      fev[i]   = '0;
      for (int k = 0; k < 2; k++) begin
        empty[i][k]       = (rd_count[i][k] >= avail[i][k]);
        fev[i][k*32 +: 32] = (pend_cnt[i][k] == 1) ? pend_word[i][k] : (32'hDEAD_0000 | 32'(k));
      end
    end
  end

  always @(negedge clk) begin
    #3;
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        if (rd_en[i] != 2'b00) begin
          check($sformatf("inst%0d_rd_onehot", i), $countones(rd_en[i]), 1);
          rd_cyc_q[i].push_back(cyc);
          rd_ch_q[i].push_back(rd_en[i][1] ? 1 : 0);
        end
        if (ev_valid[i] && ev_ready[i]) begin
          pop_cyc_q[i].push_back(cyc);
          pop_ch_q[i].push_back(int'(ev_ch[i]));
          pop_data_q[i].push_back(ev_data[i]);
          $display("[TB] inst%0d cyc %0d event ch%0d data 0x%08h", i, cyc, ev_ch[i], ev_data[i]);
        end
      end
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      rd_cyc_q[i].delete();
      rd_ch_q[i].delete();
      pop_cyc_q[i].delete();
      pop_ch_q[i].delete();
      pop_data_q[i].delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      grant[i]    = 2'b00;
      ev_ready[i] = 1'b0;
      for (int k = 0; k < 2; k++) avail[i][k] = rd_count[i][k];
    end
    @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
  endtask

  int c0, b, b0, b1, n0, n1, k;
  int exp_ch[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};

  initial begin
    grant[0] = 2'b00; grant[1] = 2'b00;
    ev_ready[0] = 1'b0; ev_ready[1] = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #4;
    check("rst_req", req[0], 0);
    check("rst_rd_en", rd_en[0], 0);
    check("rst_ev_valid", ev_valid[0], 0);
    check("rst_ev_data", ev_data[0], 0);
    check("rst_ev_ch", ev_ch[0], 0);

    // Single read, grant two cycles after request
    @(negedge clk);
    rst_n = 1'b1;
    ev_ready[0] = 1'b1;
    @(negedge clk);
    c0 = cyc;
    avail[0][0] = rd_count[0][0] + 1;
    @(negedge clk); #4;
    check("t1_req_next_cycle", req[0], 2'b01);
    check("t1_no_rd_before_grant", rd_en[0], 0);
    @(negedge clk);
    grant[0][0] = 1'b1;
    repeat (8) @(negedge clk);
    #4;
    check("t1_rd_pulses", rd_cyc_q[0].size(), 1);
    check("t1_rd_cycle", qi(rd_cyc_q[0], 0), c0 + 3);
    check("t1_data", qd(pop_data_q[0], 0), 32'hA5A5_0001);
    check("t1_ch", qi(pop_ch_q[0], 0), 0);
    check("t1_valid_cycle", qi(pop_cyc_q[0], 0), c0 + 5);

    // Round-robin bursts: 6 events on each channel
    do_reset();
    ev_ready[0] = 1'b1;
    grant[0] = 2'b11;
    b0 = rd_count[0][0];
    b1 = rd_count[0][1];
    avail[0][0] = b0 + 6;
    avail[0][1] = b1 + 6;
    repeat (70) @(negedge clk);
    #4;
    check("t2_event_count", pop_data_q[0].size(), 12);
    n0 = 0; n1 = 0;
    for (int j = 0; j < 12; j++) begin
      k = exp_ch[j];
      if (k == 0) begin
        check($sformatf("t2_ev%0d", j), qd(pop_data_q[0], j), word(0, 0, b0 + n0));
        n0++;
      end else begin
        check($sformatf("t2_ev%0d", j), qd(pop_data_q[0], j), word(0, 1, b1 + n1));
        n1++;
      end
    end

    // Back-pressure: buffer fills at 4, then a one-cycle ready pulse frees one slot
    do_reset();
    grant[0] = 2'b01;
    b = rd_count[0][0];
    avail[0][0] = b + 6;
    repeat (40) @(negedge clk);
    #4;
    check("t3_reads_when_full", rd_cyc_q[0].size(), 4);
    check("t3_req_held", req[0], 2'b01);
    check("t3_no_rd_when_full", rd_en[0], 0);
    check("t3_valid", ev_valid[0], 1);
    @(negedge clk);
    ev_ready[0] = 1'b1;
    @(negedge clk);
    ev_ready[0] = 1'b0;
    repeat (20) @(negedge clk);
    #4;
    check("t3_reads_after_pulse", rd_cyc_q[0].size(), 5);
    check("t3_pops", pop_data_q[0].size(), 1);
    check("t3_pop_data", qd(pop_data_q[0], 0), word(0, 0, b));
    check("t3_req_still_held", req[0], 2'b01);

    // Latency 3: two-event burst on the second instance
    do_reset();
    grant[1] = 2'b01;
    ev_ready[1] = 1'b1;
    b = rd_count[1][0];
    avail[1][0] = b + 2;
    repeat (30) @(negedge clk);
    #4;
    check("t4_reads", rd_cyc_q[1].size(), 2);
    check("t4_rd_spacing", qi(rd_cyc_q[1], 1) - qi(rd_cyc_q[1], 0), 4);
    check("t4_pops", pop_data_q[1].size(), 2);
    check("t4_data0", qd(pop_data_q[1], 0), word(1, 0, b));
    check("t4_data1", qd(pop_data_q[1], 1), word(1, 0, b + 1));
    check("t4_lat0", qi(pop_cyc_q[1], 0) - qi(rd_cyc_q[1], 0), 4);
    check("t4_lat1", qi(pop_cyc_q[1], 1) - qi(rd_cyc_q[1], 1), 4);

    // Grant drops during the READ of the second burst event
    do_reset();
    grant[0] = 2'b01;
    ev_ready[0] = 1'b1;
    b = rd_count[0][0];
    avail[0][0] = b + 6;
    for (int t = 0; t < 40 && rd_cyc_q[0].size() < 2; t++) begin
      @(negedge clk); #4;
    end
    @(negedge clk);
    grant[0][0] = 1'b0;
    @(negedge clk); #4;
    check("t5_release_req", req[0], 0);
    repeat (15) @(negedge clk);
    #4;
    check("t5_reads", rd_cyc_q[0].size(), 2);
    check("t5_pops", pop_data_q[0].size(), 2);
    check("t5_second_data", qd(pop_data_q[0], 1), word(0, 0, b + 1));
    check("t5_req_waiting", req[0], 2'b01);
    check("t5_no_rd", rd_en[0], 0);

    // Asynchronous reset with three events buffered and ch1 requesting
    do_reset();
    grant[0] = 2'b01;
    b0 = rd_count[0][0];
    avail[0][0] = b0 + 3;
    avail[0][1] = rd_count[0][1] + 1;
    repeat (20) @(negedge clk);
    #4;
    check("t6_valid_before", ev_valid[0], 1);
    check("t6_req_ch1_before", req[0], 2'b10);
    rst_n = 1'b0;
    #1;
    check("t6_valid_in_reset", ev_valid[0], 0);
    check("t6_req_in_reset", req[0], 0);
    check("t6_rd_in_reset", rd_en[0], 0);
    clear_logs();
    grant[0] = 2'b11;
    ev_ready[0] = 1'b1;
    avail[0][0] = rd_count[0][0] + 2;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #4;
    check("t6_first_rd_ch", qi(rd_ch_q[0], 0), 0);
    check("t6_first_data", qd(pop_data_q[0], 0), word(0, 0, b0 + 3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
